// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the registered ALU.
//   - 4-bit opcode constants decoded by alu_core and alu_seq.
//   - state_t: control states of alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU datapath.
// Ports:
//   i_a, i_b    operands (WIDTH bits)
//   i_op        4-bit opcode
//   o_result    truncated result; 0 for unsupported opcodes
//   o_overflow  signed overflow of ADD/SUB, 0 otherwise
//   o_err       opcode not handled here (MUL is also flagged; the parent overrides it)
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_err
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_lt   = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_err      = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            OP_NOR: o_result = ~(i_a | i_b);
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Optional feature macro: ALU_SEQ_MUL_EN adds an iterative shift-add MUL (opcode 1000).
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operation handshake for a, b, ALUOp
//   out_valid / out_ready result handshake for Result, Zero, Overflow, out_err
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             out_err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;
    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_ovf;
    logic             w_core_err;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_a        (a),
        .i_b        (b),
        .i_op       (ALUOp),
        .o_result   (w_core_result),
        .o_overflow (w_core_ovf),
        .o_err      (w_core_err)
    );

    // A held result can be replaced in the same cycle it is consumed.
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign Result    = r_result;
    assign Zero      = r_zero;
    assign Overflow  = r_ovf;
    assign out_err   = r_err;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_last;

    assign w_is_mul   = (ALUOp == OP_MUL);
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);

    // One multiplier bit per BUSY cycle; the multiplicand shifts up as the multiplier drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_is_mul = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? BUSY : DONE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (w_mul_last) begin
                    w_state_next = DONE;
                end
            end
`endif
            DONE: begin
                if (w_accept) begin
                    w_state_next = w_is_mul ? BUSY : DONE;
                end else if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && !w_is_mul) begin
                r_result <= w_core_result;
                r_zero   <= (w_core_result == '0);
                r_ovf    <= w_core_ovf;
                r_err    <= w_core_err;
            end
`ifdef ALU_SEQ_MUL_EN
            else if ((r_state == BUSY) && w_mul_last) begin
                r_result <= w_acc_next;
                r_zero   <= (w_acc_next == '0);
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int unsigned W = 64;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   ALUOp = 4'b0000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;
    logic         out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_phase = 1'b0;
    exp_t sb[$];

    localparam logic signed [W:0] MAXP = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] MINN = {2'b11, {(W-1){1'b0}}};

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed overflow means the exact sum does not fit in W signed bits.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [3:0] op);
        exp_t e;
        logic signed [W:0] s;
        e = '0;
        s = '0;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: begin
                s = $signed({x[W-1], x}) + $signed({y[W-1], y});
                e.res = s[W-1:0];
                e.ov = (s > MAXP) || (s < MINN);
            end
            4'b0110: begin
                s = $signed({x[W-1], x}) - $signed({y[W-1], y});
                e.res = s[W-1:0];
                e.ov = (s > MAXP) || (s < MINN);
            end
            4'b0111: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'b1100: e.res = ~(x | y);
`ifdef ALU_SEQ_MUL_EN
            4'b1000: e.res = x * y;
`endif
            default: e.err = 1'b1;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer an op and return #1 after the edge that accepted it; in_valid stays high.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op);
        bit done;
        done = 1'b0;
        a = x;
        b = y;
        ALUOp = op;
        in_valid = 1'b1;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(x, y, op));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op %b never accepted", op);
        end
    endtask

    // Drop valid and scramble the operands; captured values must not change.
    task automatic idle();
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        ALUOp = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic measure(input string name, input int exp_lat);
        int lat;
        int ir_busy;
        bit got;
        lat = 0;
        ir_busy = 0;
        got = 1'b0;
        for (int c = 1; c <= int'(W) + 20 && !got; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                got = 1'b1;
            end else if (in_ready) begin
                ir_busy++;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_latency"}, W'(lat), W'(exp_lat));
        chk({name, "_in_ready_busy"}, W'(ir_busy), W'(0));
    endtask

    // Scoreboard monitor: a transfer is visible once per cycle at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: Result 0x%0h with no expected entry", Result);
                end else begin
                    e = sb.pop_front();
                    if ({Result, Zero, Overflow, out_err} !== e) begin
                        errors++;
                        $display("FAIL sb_compare: got R=0x%0h Z=%0b O=%0b E=%0b expected R=0x%0h Z=%0b O=%0b E=%0b",
                                 Result, Zero, Overflow, out_err, e.res, e.z, e.ov, e.err);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_phase) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int t0;
        int t_last;
        logic [3:0] op;
        logic [W-1:0] x;
        logic [W-1:0] y;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result", Result, W'(0));
        chk("rst_flags", W'({Zero, Overflow, out_err}), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        wait_cycles(1);

        // Reset during an operation in flight (BUSY when MUL is built).
        out_ready = 1'b0;
        issue(W'(14), W'(10), 4'b1000);
        idle();
        wait_cycles(10);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", W'(out_valid), W'(0));
        chk("rst_mid_result", Result, W'(0));
        sb.delete();
        wait_cycles(2);
        reset = 1'b0;
        #1;
        chk("rst_mid_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        wait_cycles(1);

        // Back-to-back basic ops, one per cycle.
        issue(W'(14), W'(10), 4'b0000);
        t0 = cyc;
        issue(W'(14), W'(10), 4'b0001);
        issue(W'(14), W'(10), 4'b0010);
        issue(W'(14), W'(10), 4'b0110);
        issue(W'(14), W'(10), 4'b1100);
        t_last = cyc;
        idle();
        chk("throughput", W'(t_last - t0), W'(4));
        wait_cycles(2);

        // Boundaries.
        issue(W'(5), W'(5), 4'b0110);
        issue({1'b0, {(W-1){1'b1}}}, W'(1), 4'b0010);
        issue({W{1'b1}}, W'(1), 4'b0111);
        issue({1'b1, {(W-1){1'b0}}}, W'(1), 4'b0110);
        idle();
        wait_cycles(2);

        // Back-pressure: result held, nothing else accepted.
        out_ready = 1'b0;
        issue(W'(14), W'(10), 4'b0010);
        a = W'(3);
        b = W'(4);
        ALUOp = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_result", Result, W'(24));
            chk("bp_in_ready", W'(in_ready), W'(0));
            @(posedge clk);
            #1;
        end
        idle();
        out_ready = 1'b1;
        wait_cycles(1);
        @(negedge clk);
        chk("bp_no_extra", W'(out_valid), W'(0));
        @(posedge clk);
        #1;

        // Latency of a single-cycle op and of MUL.
        issue(W'(14), W'(10), 4'b0010);
        idle();
        measure("add", 1);
        wait_cycles(1);
        issue(W'(14), W'(10), 4'b1000);
        idle();
`ifdef ALU_SEQ_MUL_EN
        measure("mul", int'(W) + 1);
`else
        measure("mul", 1);
`endif
        wait_cycles(1);

        // Unsupported opcode, then a valid op clears the error.
        issue(W'(14), W'(10), 4'b1111);
        issue(W'(14), W'(10), 4'b0000);
        idle();
        wait_cycles(3);

        // Randomised traffic with random back-pressure.
        rnd_phase = 1'b1;
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 6))
                    0: op = 4'b0000;
                    1: op = 4'b0001;
                    2: op = 4'b0010;
                    3: op = 4'b0110;
                    4: op = 4'b0111;
                    5: op = 4'b1100;
                    default: op = 4'b1000;
                endcase
            end
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: y = x;
                1: x = {1'b0, {(W-1){1'b1}}};
                2: y = {1'b1, {(W-1){1'b0}}};
                3: y = W'($urandom_range(0, 3));
                default: ;
            endcase
            issue(x, y, op);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                wait_cycles(int'($urandom_range(1, 3)));
            end
        end
        idle();
        wait_cycles(1);
        rnd_phase = 1'b0;
        wait_cycles(1);
        out_ready = 1'b1;

        for (int k = 0; k < 500 && sb.size() != 0; k++) wait_cycles(1);
        wait_cycles(2);
        chk("sb_drained", W'(sb.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 64-bit combinational ALU. It accepts one operation per handshake, registers the result together with its Zero, Overflow and error flags, and holds that result until the consumer takes it. An optional iterative multiplier adds a multi-cycle operation. It sits between the register-file read stage and writeback in the datapath, and its valid/ready handshakes let it stall the stages on either side.

## Interface
Parameters:
- WIDTH, 64, operand and result width; must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered on a, b, ALUOp
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ALUOp  in  4  operation code
- out_valid  out  1  Result and flags are valid
- out_ready  in  1  consumer takes the result this cycle
- Result  out  WIDTH  registered result
- Zero  out  1  Result == 0
- Overflow  out  1  signed overflow of ADD/SUB; 0 for all other ops
- out_err  out  1  ALUOp was unsupported

## Operation
Opcodes:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB (a−b)
- 0111 SLT (signed; Result = 1 or 0)
- 1100 NOR
- 1000 MUL: only when ALU_SEQ_MUL_EN is defined.

Arithmetic rules:
- Every result is truncated to WIDTH bits.
- ADD Overflow = operand signs equal and result sign differs.
- SUB Overflow = operand signs differ and result sign differs from a.

Unsupported opcode:
- Result = 0, Zero = 1, out_err = 1, Overflow = 0.
- Completes with single-cycle latency.

States:
- IDLE: in_ready = 1.
  - Accepting a single-cycle op → DONE.
  - Accepting MUL → BUSY.
- BUSY: in_ready = 0.
  - Shift-add over an internal counter running 0..WIDTH−1.
  - On the last count → DONE.
- DONE: out_valid = 1; outputs held stable.
  - out_ready = 1 and no new accept → IDLE.
  - in_ready = out_ready. A new op accepted in the same cycle goes directly to DONE (single-cycle op) or BUSY (MUL).

Handshake rules:
- A transfer occurs only when valid and ready are both 1.
- Operands are captured at accept; later changes on a, b, ALUOp have no effect.
- out_valid never drops without out_ready.

Reset:
- Asynchronous; returns the block to IDLE and aborts any BUSY multiply with no out_valid.
- Reset values: Result 0, Zero 0, Overflow 0, out_err 0, out_valid 0. in_ready = 1 once reset deasserts.

## Timing
- Single-cycle ops: out_valid is asserted on the cycle after the accept edge.
- Sustained throughput with out_ready held at 1: one op per cycle.
- MUL: out_valid is asserted WIDTH+1 cycles after the accept edge.
- Back-pressure: with out_ready = 0 the result holds indefinitely and in_ready stays 0.
- in_ready is combinational from the state and out_ready. There is no combinational path from in_valid to any output.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - MUL (1000) is supported, including the BUSY state and counter.
  - Result = low WIDTH bits of a×b (unsigned); Overflow = 0.
- ALU_SEQ_MUL_EN undefined:
  - 1000 is treated as an unsupported opcode.
  - BUSY, the counter and the multiplier registers are not built; the block is purely single-cycle.

## Structure
- Package alu_seq_pkg:
  - Opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL).
  - State enum (IDLE, BUSY, DONE).
- Sub-module alu_core: combinational, parametrised by WIDTH.
  - Implements every single-cycle op and the Overflow and out_err flags.
  - Instantiated once; its outputs are registered at accept.
- The multiplier datapath and counter are written inline in alu_seq under ALU_SEQ_MUL_EN.

## Test plan
All scenarios use a = 14, b = 10 unless stated.
1. Reset mid-operation: assert reset during BUSY of a MUL → out_valid = 0, Result = 0; in_ready = 1 after release.
2. out_ready = 1, ops AND, OR, ADD, SUB, NOR back-to-back → Result 10, 14, 24, 4, 0xFFFF_FFFF_FFFF_FFF1, one per cycle; Zero = 0 throughout.
3. Boundary values:
   - SUB with a = b = 5 → Result 0, Zero = 1.
   - ADD 0x7FFF…F + 1 → 0x8000…0, Overflow = 1.
   - SLT with a = −1, b = 1 → Result 1.
4. Back-pressure: out_ready held at 0 for 5 cycles after an ADD → Result stays 24, out_valid stays 1, in_ready stays 0, and an op held on the inputs is not accepted.
5. MUL 14×10 with the macro defined → in_ready = 0 for 64 cycles, Result 140 at cycle 65 after accept. With the macro undefined → out_err = 1, Result 0.
6. Unsupported ALUOp 1111 → out_err = 1, Zero = 1, Result 0; the next valid op clears out_err.
